fft_agu: RTL and testbench

FFT_AGU -- requirements
Module: fft_agu

---
 rtl/fft_agu_pkg.sv | 16 +
 rtl/fft_agu_bitrev.sv | 17 +
 rtl/fft_agu.sv | 210 +++++++++++++++++++++
 tb/tb_fft_agu.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fft_agu_pkg.sv
// Shared types and constants for the FFT address generator.
// FSM state encoding, sweep-mode constants and the stage output width.
package fft_agu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } agu_state_e;

  localparam logic MODE_BFLY = 1'b0;
  localparam logic MODE_BREV = 1'b1;

  localparam int STAGE_W = 4;

endpackage

// File: rtl/fft_agu_bitrev.sv
// Combinational bit reversal of an FFTSIZ-bit index.
// Only instantiated when FFT_AGU_BITREV_EN is defined.
module fft_bitrev #(
  parameter int FFTSIZ = 3
) (
  input  logic [FFTSIZ-1:0] idx_i,
  output logic [FFTSIZ-1:0] rev_o
);

  always_comb begin
    rev_o = '0;
    for (int b = 0; b < FFTSIZ; b++) begin
      rev_o[b] = idx_i[FFTSIZ-1-b];
    end
  end

endmodule

// File: rtl/fft_agu.sv
// FFT address generator: butterfly operand sweep or in-place bit-reverse swap list.
// Optional feature macro: FFT_AGU_BITREV_EN enables the bit-reverse mode.
module fft_agu
  import fft_agu_pkg::*;
#(
  parameter int MDATAW = 8,
  parameter int FFTSIZ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [MDATAW-1:0]  base,
  input  logic               rdy,
  output logic               vld,
  output logic [MDATAW-1:0]  addr_a,
  output logic [MDATAW-1:0]  addr_b,
  output logic [FFTSIZ-1:0]  twd,
  output logic [STAGE_W-1:0] stage,
  output logic               busy,
  output logic               done,
  output logic [1:0]         dbg_state
);

  // Handshake: a pair is consumed on a rising edge where vld and rdy are both
  // high; while vld is high and rdy low, every output holds its value.

  localparam int                 N      = 1 << FFTSIZ;
  localparam logic [FFTSIZ-1:0]  K_LAST = FFTSIZ'(N / 2 - 1);
  localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(FFTSIZ - 1);

  agu_state_e         state_q;
  logic [STAGE_W-1:0] s_q;
  logic [FFTSIZ-1:0]  k_q;
  logic [MDATAW-1:0]  base_q;
  logic               vld_q, busy_q, done_q;
  logic [MDATAW-1:0]  addr_a_q, addr_b_q;
  logic [FFTSIZ-1:0]  twd_q;
  logic [STAGE_W-1:0] stage_q;

  logic               first;
  logic               brev_cur;
  logic               have_nx;
  logic               load;
  logic [STAGE_W-1:0] s_nx;
  logic [FFTSIZ-1:0]  k_nx;
  logic [FFTSIZ-1:0]  half_m, jmask, j_ix;
  logic [FFTSIZ-1:0]  top_ix, bot_ix, twd_nx;
  logic [MDATAW-1:0]  base_cur;

  assign first    = (state_q == IDLE);
  assign base_cur = first ? base : base_q;

`ifdef FFT_AGU_BITREV_EN
  logic              mode_q;
  logic              brev_found;
  logic [FFTSIZ-1:0] brev_idx;
  logic [FFTSIZ-1:0] rev_ix;
  logic [FFTSIZ:0]   srch_from;

  assign brev_cur = first ? (mode == MODE_BREV) : (mode_q == MODE_BREV);

  // Qualification i < rev(i) depends only on the loop constant, so the search
  // reduces to a priority pick over a fixed mask above the current index.
  function automatic logic brev_qual(input int c);
    int r;
    r = 0;
    for (int b = 0; b < FFTSIZ; b++) begin
      if (c[b]) r = r | (1 << (FFTSIZ - 1 - b));
    end
    return c < r;
  endfunction

  assign srch_from = first ? '0 : ({1'b0, k_q} + 1'b1);

  always_comb begin
    brev_found = 1'b0;
    brev_idx   = '0;
    for (int c = N - 1; c >= 0; c--) begin
      if (brev_qual(c) && (c >= int'(srch_from))) begin
        brev_found = 1'b1;
        brev_idx   = FFTSIZ'(c);
      end
    end
  end

  fft_bitrev #(.FFTSIZ(FFTSIZ)) u_bitrev (
    .idx_i (k_nx),
    .rev_o (rev_ix)
  );
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign brev_cur    = 1'b0;
`endif

  // Next counter position; have_nx low means the sweep has no further pair.
  always_comb begin
    s_nx    = s_q;
    k_nx    = k_q;
    have_nx = 1'b0;
`ifdef FFT_AGU_BITREV_EN
    if (brev_cur) begin
      s_nx    = '0;
      k_nx    = brev_idx;
      have_nx = brev_found;
    end else
`endif
    if (first) begin
      s_nx    = '0;
      k_nx    = '0;
      have_nx = 1'b1;
    end else if (k_q == K_LAST) begin
      if (s_q != S_LAST) begin
        s_nx    = s_q + 1'b1;
        k_nx    = '0;
        have_nx = 1'b1;
      end
    end else begin
      k_nx    = k_q + 1'b1;
      have_nx = 1'b1;
    end
  end

  always_comb begin
    half_m = FFTSIZ'(1) << s_nx;
    jmask  = half_m - 1'b1;
    j_ix   = k_nx & jmask;
    top_ix = ((k_nx & ~jmask) << 1) | j_ix;
    bot_ix = top_ix | half_m;
    twd_nx = j_ix << (S_LAST - s_nx);
`ifdef FFT_AGU_BITREV_EN
    if (brev_cur) begin
      top_ix = k_nx;
      bot_ix = rev_ix;
      twd_nx = '0;
    end
`endif
  end

  assign load = have_nx &&
                ((first && start) || (state_q == RUN && !abort && vld_q && rdy));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      s_q      <= '0;
      k_q      <= '0;
      base_q   <= '0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      twd_q    <= '0;
      stage_q  <= '0;
`ifdef FFT_AGU_BITREV_EN
      mode_q   <= MODE_BFLY;
`endif
    end else begin
      done_q <= 1'b0;
      if (load) begin
        s_q      <= s_nx;
        k_q      <= k_nx;
        addr_a_q <= base_cur + MDATAW'({top_ix, 1'b0});
        addr_b_q <= base_cur + MDATAW'({bot_ix, 1'b0});
        twd_q    <= twd_nx;
        stage_q  <= brev_cur ? '0 : s_nx;
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            vld_q   <= have_nx;
            base_q  <= base;
`ifdef FFT_AGU_BITREV_EN
            mode_q  <= mode;
`endif
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
          end else if (!vld_q || (rdy && !have_nx)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vld       = vld_q;
  assign addr_a    = addr_a_q;
  assign addr_b    = addr_b_q;
  assign twd       = twd_q;
  assign stage     = stage_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fft_agu.sv
// Directed bench for fft_agu at MDATAW=8, FFTSIZ=3 with hand-computed pair tables.
module tb_fft_agu;

  logic       clk, rst, start, abort, mode, rdy;
  logic [7:0] base;
  logic       vld, busy, done;
  logic [7:0] addr_a, addr_b;
  logic [2:0] twd;
  logic [3:0] stage;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_errs   = 0;

`ifdef FFT_AGU_BITREV_EN
  localparam bit BREV_EN = 1'b1;
`else
  localparam bit BREV_EN = 1'b0;
`endif

  // Butterfly index pairs for N=8, in emission order.
  localparam int BF_TOP [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  localparam int BF_BOT [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  localparam int BF_TWD [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  localparam int BF_STG [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
  localparam int BR_TOP [2]  = '{1, 3};
  localparam int BR_BOT [2]  = '{4, 6};

  fft_agu #(.MDATAW(8), .FFTSIZ(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .base      (base),
    .rdy       (rdy),
    .vld       (vld),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .twd       (twd),
    .stage     (stage),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_vld"},    vld,    0);
    check({pfx, "_busy"},   busy,   0);
    check({pfx, "_done"},   done,   0);
    check({pfx, "_addr_a"}, addr_a, 0);
    check({pfx, "_addr_b"}, addr_b, 0);
    check({pfx, "_twd"},    twd,    0);
    check({pfx, "_stage"},  stage,  0);
  endtask

  task automatic check_pair(input logic [7:0] b, input bit br, input int n);
    logic [7:0] ea, eb;
    int         et, es;
    if (br) begin
      ea = b + 8'(2 * BR_TOP[n]);
      eb = b + 8'(2 * BR_BOT[n]);
      et = 0;
      es = 0;
    end else begin
      ea = b + 8'(2 * BF_TOP[n]);
      eb = b + 8'(2 * BF_BOT[n]);
      et = BF_TWD[n];
      es = BF_STG[n];
    end
    check($sformatf("pair%0d_addr_a", n), addr_a, ea);
    check($sformatf("pair%0d_addr_b", n), addr_b, eb);
    check($sformatf("pair%0d_twd", n),    twd,    et);
    check($sformatf("pair%0d_stage", n),  stage,  es);
  endtask

  // Runs one sweep; stall_at holds rdy low for 5 cycles on that pair (start is
  // pulsed meanwhile and must be ignored), abort_at aborts while that pair is offered.
  task automatic sweep(input logic [7:0] b, input logic m, input int stall_at, input int abort_at);
    int n, stall, n_exp;
    bit br, last, fin;
    br    = BREV_EN && m;
    n_exp = br ? 2 : 12;
    n = 0; stall = 0; last = 0; fin = 0;
    base = b; mode = m; start = 1'b1; rdy = 1'b1; abort = 1'b0;
    @(negedge clk);
    start = 1'b0;
    base  = ~b;
    mode  = ~m;
    check("first_vld",  vld,  1);
    check("first_busy", busy, 1);
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      abort = 1'b0;
      if (last) begin
        check("done_pulse", done, 1);
        check("done_busy",  busy, 0);
        check("done_vld",   vld,  0);
        fin = 1;
      end else if (vld !== 1'b1) begin
        check("run_vld", vld, 1);
        fin = 1;
      end else begin
        check_pair(b, br, n);
        if (b == 8'hFC && n == 3) begin
          check("wrap_addr_a", addr_a, 8'h08);
          check("wrap_addr_b", addr_b, 8'h0A);
        end
        if (n == stall_at && stall < 5) begin
          rdy   = 1'b0;
          start = 1'b1;
          stall++;
        end else begin
          rdy   = 1'b1;
          start = 1'b0;
          if (n == abort_at) begin
            abort = 1'b1;
            fin   = 1;
          end
          n++;
          if (n == n_exp) last = 1;
        end
      end
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
    rdy   = 1'b1;
    if (!fin) check("sweep_timeout", 0, 1);
    if (abort_at >= 0) begin
      check("abort_busy", busy, 0);
      check("abort_vld",  vld,  0);
      for (int i = 0; i < 4; i++) begin
        check("abort_no_done", done, 0);
        @(negedge clk);
      end
    end else begin
      check("done_one_cycle", done, 0);
      check("pair_count", n, n_exp);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; rdy = 1'b1; base = 8'h00;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_vld", vld, 0);

    sweep(8'h10, 1'b0, -1, -1);
    sweep(8'h10, 1'b0,  5, -1);
    sweep(8'h10, 1'b1, -1, -1);
    sweep(8'hFC, 1'b0, -1, -1);
    sweep(8'h10, 1'b0, -1,  3);
    sweep(8'h10, 1'b0, -1, -1);

    // Reset in the middle of a sweep.
    base = 8'h10; mode = 1'b0; start = 1'b1; rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_zero_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check("postrst_vld",  vld,  0);
    check("postrst_busy", busy, 0);
    sweep(8'h10, 1'b0, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
